// File: rtl/pcm_sched_pkg.sv
// Shared types and widths for the PCM transmit scheduler.
package pcm_sched_pkg;

  localparam int unsigned PCM_W  = 16;
  localparam int unsigned NUM_CH = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} sched_state_t;

  typedef logic [PCM_W-1:0] pcm_t;

endpackage

// File: rtl/pcm_fifo.sv
// Single-clock FIFO with a registered occupancy count; full/empty decode from that count.
module pcm_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_FULL);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/pcm_tx_scheduler.sv
// Round-robin two-channel PCM scheduler with paced issue strobes for the SPI transmitter.
// Build option CHAN_TAG_EN: replace pcm_out[0] with the issuing channel id.
module pcm_tx_scheduler
  import pcm_sched_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             ch0_valid,
  input  logic [PCM_W-1:0] ch0_data,
  output logic             ch0_ready,
  input  logic             ch1_valid,
  input  logic [PCM_W-1:0] ch1_data,
  output logic             ch1_ready,
  input  logic             ovf_clr,
  output logic             audio_valid,
  output logic [PCM_W-1:0] pcm_out,
  output logic             chan_sel,
  output logic [1:0]       ovf,
  output logic             busy
);

  localparam int unsigned CW = $clog2(GAP_CYCLES);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 3);
  localparam logic [CW-1:0] GAP_ONE  = 1;

  sched_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic          r_grant, w_grant_nxt;
  logic          r_last_grant, w_last_grant_nxt;
  logic          r_audio_valid, w_audio_valid_nxt;
  pcm_t          r_pcm_out, w_pcm_out_nxt;
  logic          r_chan_sel, w_chan_sel_nxt;
  logic [1:0]    r_ovf, w_ovf_nxt;

  pcm_t           w_rdata0, w_rdata1, w_sample, w_issue_data;
  logic           w_full0, w_full1, w_empty0, w_empty1;
  logic [FCW-1:0] w_count0, w_count1;
  logic           w_push0, w_push1, w_pop0, w_pop1;
  logic           w_has0, w_has1;

  assign ch0_ready = !w_full0;
  assign ch1_ready = !w_full1;
  assign w_push0   = ch0_valid && ch0_ready;
  assign w_push1   = ch1_valid && ch1_ready;
  assign w_has0    = (w_count0 != '0);
  assign w_has1    = (w_count1 != '0);

  pcm_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PCM_W)) u_fifo_ch0 (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (w_push0),
    .pop    (w_pop0),
    .wdata  (ch0_data),
    .rdata  (w_rdata0),
    .full   (w_full0),
    .empty  (w_empty0),
    .count  (w_count0)
  );

  pcm_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PCM_W)) u_fifo_ch1 (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (w_push1),
    .pop    (w_pop1),
    .wdata  (ch1_data),
    .rdata  (w_rdata1),
    .full   (w_full1),
    .empty  (w_empty1),
    .count  (w_count1)
  );

  assign w_sample = r_grant ? w_rdata1 : w_rdata0;
`ifdef CHAN_TAG_EN
  assign w_issue_data = {w_sample[PCM_W-1:1], r_grant};
`else
  assign w_issue_data = w_sample;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_gap_cnt_nxt     = r_gap_cnt;
    w_grant_nxt       = r_grant;
    w_last_grant_nxt  = r_last_grant;
    w_audio_valid_nxt = 1'b0;
    w_pcm_out_nxt     = r_pcm_out;
    w_chan_sel_nxt    = r_chan_sel;
    w_pop0            = 1'b0;
    w_pop1            = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable && (w_has0 || w_has1)) begin
          w_state_nxt = S_ISSUE;
          w_grant_nxt = (w_has0 && w_has1) ? !r_last_grant : w_has1;
        end
      end
      S_ISSUE: begin
        w_pop0            = !r_grant && !w_empty0;
        w_pop1            = r_grant && !w_empty1;
        w_audio_valid_nxt = 1'b1;
        w_pcm_out_nxt     = w_issue_data;
        w_chan_sel_nxt    = r_grant;
        w_last_grant_nxt  = r_grant;
        w_gap_cnt_nxt     = GAP_LOAD;
        w_state_nxt       = S_GAP;
      end
      S_GAP: begin
        // IDLE + ISSUE + (GAP_CYCLES-2) gap cycles give the exact strobe period.
        if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
        else                 w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Set beats clear when both land on the same edge.
  assign w_ovf_nxt = (ovf_clr ? 2'b00 : r_ovf)
                   | {ch1_valid && !ch1_ready, ch0_valid && !ch0_ready};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_gap_cnt     <= '0;
      r_grant       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_audio_valid <= 1'b0;
      r_pcm_out     <= '0;
      r_chan_sel    <= 1'b0;
      r_ovf         <= 2'b00;
    end else begin
      r_state       <= w_state_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_grant       <= w_grant_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_audio_valid <= w_audio_valid_nxt;
      r_pcm_out     <= w_pcm_out_nxt;
      r_chan_sel    <= w_chan_sel_nxt;
      r_ovf         <= w_ovf_nxt;
    end
  end

  assign audio_valid = r_audio_valid;
  assign pcm_out     = r_pcm_out;
  assign chan_sel    = r_chan_sel;
  assign ovf         = r_ovf;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_pcm_tx_scheduler.sv
// Directed-vector bench for pcm_tx_scheduler; strobes are logged by a negedge monitor.
module tb_pcm_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        ch0_valid = 1'b0;
  logic        ch1_valid = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [15:0] ch0_data = '0;
  logic [15:0] ch1_data = '0;
  logic        ch0_ready, ch1_ready, audio_valid, chan_sel, busy;
  logic [15:0] pcm_out;
  logic [1:0]  ovf;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int          p_cyc[$];
  logic [15:0] p_dat[$];
  logic        p_ch[$];
  int          c0;

`ifdef CHAN_TAG_EN
  localparam logic [15:0] EXP_TAGGED = 16'h8001;
`else
  localparam logic [15:0] EXP_TAGGED = 16'h8000;
`endif

  pcm_tx_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .ch0_valid  (ch0_valid),
    .ch0_data   (ch0_data),
    .ch0_ready  (ch0_ready),
    .ch1_valid  (ch1_valid),
    .ch1_data   (ch1_data),
    .ch1_ready  (ch1_ready),
    .ovf_clr    (ovf_clr),
    .audio_valid(audio_valid),
    .pcm_out    (pcm_out),
    .chan_sel   (chan_sel),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (audio_valid) begin
      p_cyc.push_back(cycle);
      p_dat.push_back(pcm_out);
      p_ch.push_back(chan_sel);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; ovf_clr = 1'b0;
    ch0_valid = 1'b0; ch1_valid = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(1);
    p_cyc.delete(); p_dat.delete(); p_ch.delete();
  endtask

  task automatic push_both(input logic v0, input logic [15:0] d0,
                           input logic v1, input logic [15:0] d1);
    ch0_valid = v0; ch0_data = d0;
    ch1_valid = v1; ch1_data = d1;
    step(1);
    ch0_valid = 1'b0; ch1_valid = 1'b0;
  endtask

  task automatic check_spacing(input string tag);
    for (int i = 1; i < p_cyc.size(); i++) check_eq(tag, p_cyc[i] - p_cyc[i-1], 16);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_eq("rst_audio_valid", audio_valid, 0);
    check_eq("rst_pcm_out", pcm_out, 0);
    check_eq("rst_chan_sel", chan_sel, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", {ch1_ready, ch0_ready}, 2'b11);

    // Single-sample latency and busy window
    enable = 1'b1;
    push_both(1'b1, 16'h1234, 1'b0, 16'h0);
    c0 = cycle;
    check_eq("lat_busy_e0", busy, 0);
    step(1);
    check_eq("lat_busy_e1", busy, 1);
    check_eq("lat_av_e1", audio_valid, 0);
    step(1);
    check_eq("lat_av_e2", audio_valid, 1);
    check_eq("lat_pcm", pcm_out, 16'h1234);
    check_eq("lat_chan", chan_sel, 0);
    step(1);
    check_eq("lat_av_e3", audio_valid, 0);
    step(12);
    check_eq("lat_busy_e15", busy, 1);
    step(1);
    check_eq("lat_busy_e16", busy, 0);
    check_eq("lat_pulses", p_cyc.size(), 1);
    if (p_cyc.size() > 0) check_eq("lat_edge", p_cyc[0] - c0, 2);

    // Interleave with both channels preloaded
    do_reset();
    push_both(1'b1, 16'h0001, 1'b1, 16'h0101);
    push_both(1'b1, 16'h0002, 1'b1, 16'h0102);
    enable = 1'b1;
    step(70);
    check_eq("rr_pulses", p_cyc.size(), 4);
    if (p_cyc.size() == 4) begin
      check_eq("rr_d0", p_dat[0], 16'h0001);
      check_eq("rr_d1", p_dat[1], 16'h0101);
      check_eq("rr_d2", p_dat[2], 16'h0002);
      check_eq("rr_d3", p_dat[3], 16'h0102);
      check_eq("rr_ch", {p_ch[3], p_ch[2], p_ch[1], p_ch[0]}, 4'b1010);
    end
    check_spacing("rr_spacing");

    // Overflow and set-beats-clear
    do_reset();
    ch0_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ch0_data = 16'h0A00 + 16'(i);
      step(1);
      if (i == 2) check_eq("ovf_ready_3", ch0_ready, 1);
      if (i == 3) check_eq("ovf_ready_4", ch0_ready, 0);
    end
    check_eq("ovf_set", ovf, 2'b01);
    ovf_clr = 1'b1; ch0_data = 16'h0A06;
    step(1);
    check_eq("ovf_set_wins", ovf, 2'b01);
    ch0_valid = 1'b0;
    step(1);
    check_eq("ovf_clr", ovf, 2'b00);
    ovf_clr = 1'b0;
    enable = 1'b1;
    step(70);
    check_eq("ovf_drain_pulses", p_cyc.size(), 4);
    for (int i = 0; i < p_dat.size(); i++) check_eq("ovf_drain_data", p_dat[i], 16'h0A00 + 16'(i));
    check_eq("ovf_ready_back", ch0_ready, 1);

    // Only ch1 active
    do_reset();
    for (int i = 0; i < 3; i++) push_both(1'b0, 16'h0, 1'b1, 16'hA001 + 16'(i));
    enable = 1'b1;
    step(60);
    check_eq("ch1_pulses", p_cyc.size(), 3);
    for (int i = 0; i < p_ch.size(); i++) check_eq("ch1_chan", p_ch[i], 1);
    for (int i = 0; i < p_dat.size(); i++) check_eq("ch1_data", p_dat[i], 16'hA001 + 16'(i));
    check_spacing("ch1_spacing");

    // Enable dropped mid-gap, then re-enabled
    do_reset();
    push_both(1'b1, 16'h0011, 1'b0, 16'h0);
    push_both(1'b1, 16'h0022, 1'b0, 16'h0);
    push_both(1'b1, 16'h0033, 1'b0, 16'h0);
    enable = 1'b1;
    step(5);
    enable = 1'b0;
    step(40);
    check_eq("dis_pulses", p_cyc.size(), 1);
    check_eq("dis_pcm_held", pcm_out, 16'h0011);
    check_eq("dis_busy", busy, 0);
    enable = 1'b1;
    c0 = cycle;
    step(5);
    check_eq("reen_pulses", p_cyc.size(), 2);
    if (p_cyc.size() == 2) begin
      check_eq("reen_edge", p_cyc[1] - c0, 2);
      check_eq("reen_data", p_dat[1], 16'h0022);
    end

    // Channel tag and asynchronous reset mid-gap
    do_reset();
    push_both(1'b0, 16'h0, 1'b1, 16'h8000);
    for (int i = 1; i < 5; i++) push_both(1'b0, 16'h0, 1'b1, 16'h1111 * 16'(i));
    check_eq("tag_ovf1", ovf, 2'b10);
    enable = 1'b1;
    step(2);
    check_eq("tag_av", audio_valid, 1);
    check_eq("tag_pcm", pcm_out, EXP_TAGGED);
    check_eq("tag_chan", chan_sel, 1);
    step(5);
    reset_n = 1'b0;
    #1;
    check_eq("arst_outputs", {audio_valid, chan_sel, busy, ovf}, 5'b0);
    check_eq("arst_pcm", pcm_out, 16'h0);
    check_eq("arst_ready", {ch1_ready, ch0_ready}, 2'b11);
    step(2);
    reset_n = 1'b1;
    step(40);
    check_eq("arst_discard", p_cyc.size(), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
